// File: rtl/l2_noc1_msg_buf_if.sv
// l2_noc1_msg_buf_if: NoC1 flit ingress and assembled-message egress of the L2 NoC1 message buffer
interface l2_noc1_msg_buf_if #(parameter int MAX_DATA = 2);
    logic                    noc1_valid_in;
    logic [63:0]             noc1_data_in;
    logic                    noc1_ready_in;
    logic                    msg_valid;
    logic                    msg_ready;
    logic [7:0]              msg_type;
    logic [7:0]              msg_mshrid;
    logic [7:0]              msg_length;
    logic [39:0]             msg_addr;
    logic [13:0]             msg_src_chipid;
    logic [7:0]              msg_src_x;
    logic [7:0]              msg_src_y;
    logic [64*MAX_DATA-1:0]  msg_data;
    logic                    msg_trunc;
    modport master (
        input  noc1_valid_in, noc1_data_in, msg_ready,
        output noc1_ready_in, msg_valid, msg_type, msg_mshrid, msg_length, msg_addr,
               msg_src_chipid, msg_src_x, msg_src_y, msg_data, msg_trunc
    );
    modport slave (
        output noc1_valid_in, noc1_data_in, msg_ready,
        input  noc1_ready_in, msg_valid, msg_type, msg_mshrid, msg_length, msg_addr,
               msg_src_chipid, msg_src_x, msg_src_y, msg_data, msg_trunc
    );
endinterface

// File: rtl/l2_noc1_msg_buf.sv
// l2_noc1_msg_buf: assembles NoC1 request flits into whole messages and queues them for pipe1
module l2_noc1_msg_buf #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_DATA   = 2
) (
    input logic                clk,
    input logic                rst_n,
    l2_noc1_msg_buf_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] LAST_IDX = 8'(2 + MAX_DATA);
    typedef enum logic {HDR, PAY} state_t;
    typedef struct packed {
        logic [7:0]             typ;
        logic [7:0]             mshrid;
        logic [7:0]             length;
        logic [39:0]            addr;
        logic [13:0]            chipid;
        logic [7:0]             x;
        logic [7:0]             y;
        logic [64*MAX_DATA-1:0] data;
        logic                   trunc;
    } rec_t;
    state_t          state, state_n;
    logic [7:0]      rem, rem_n, idx, idx_n;
    rec_t            cur, cur_n, head;
    rec_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            acc, push, pop;
    // ready depends only on registered occupancy, so a full FIFO stalls even mid-message
    assign bus.noc1_ready_in = count < CW'(FIFO_DEPTH);
    assign bus.msg_valid     = count != '0;
    assign acc = bus.noc1_valid_in & bus.noc1_ready_in;
    assign pop = bus.msg_valid & bus.msg_ready;
    always_comb begin
        state_n = state;
        rem_n   = rem;
        idx_n   = idx;
        cur_n   = cur;
        push    = 1'b0;
        if (acc && state == HDR) begin
            cur_n        = '0;
            cur_n.typ    = bus.noc1_data_in[21:14];
            cur_n.mshrid = bus.noc1_data_in[13:6];
            cur_n.length = bus.noc1_data_in[29:22];
            rem_n        = bus.noc1_data_in[29:22];
            idx_n        = 8'd1;
            push         = bus.noc1_data_in[29:22] == 8'd0;
            state_n      = push ? HDR : PAY;
        end else if (acc) begin
            if (idx == 8'd1)
                cur_n.addr = bus.noc1_data_in[39:0];
            else if (idx == 8'd2)
                {cur_n.chipid, cur_n.x, cur_n.y} = bus.noc1_data_in[63:34];
            else if (idx > LAST_IDX)
                cur_n.trunc = 1'b1;
            else
                for (int k = 0; k < MAX_DATA; k++)
                    if (idx == 8'(k + 3)) cur_n.data[k*64 +: 64] = bus.noc1_data_in;
            rem_n   = rem - 8'd1;
            idx_n   = idx == 8'hff ? idx : idx + 8'd1;
            push    = rem == 8'd1;
            state_n = push ? HDR : PAY;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
            rem   <= '0;
            idx   <= '0;
            cur   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            idx   <= idx_n;
            cur   <= cur_n;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= cur_n;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end
    assign head               = mem[rd_ptr];
    assign bus.msg_type       = head.typ;
    assign bus.msg_mshrid     = head.mshrid;
    assign bus.msg_length     = head.length;
    assign bus.msg_addr       = head.addr;
    assign bus.msg_src_chipid = head.chipid;
    assign bus.msg_src_x      = head.x;
    assign bus.msg_src_y      = head.y;
    assign bus.msg_data       = head.data;
    assign bus.msg_trunc      = head.trunc;
endmodule

// File: doc/l2_noc1_msg_buf.md
# l2_noc1_msg_buf

NoC1 ingress stage of the L2 slice: accepts 64-bit request flits from NoC1 over a valid/ready handshake, parses the header, and assembles each message into one wide record. Completed messages go into a small FIFO that feeds pipe1 of the L2 over a valid/ready message interface. The block sits directly upstream of pipe1 stage S1; `noc1_ready_in` of the L2 top is driven from here.

## Interface
- `FIFO_DEPTH`, 2: completed-message entries; power of two, 2–4.
- `MAX_DATA`, 2: data flits captured after the two fixed payload flits; further flits are discarded.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `noc1_valid_in` in 1: flit valid from NoC1.
- `noc1_data_in` in 64: flit.
- `noc1_ready_in` out 1: flit accepted when `noc1_valid_in & noc1_ready_in`.
- `msg_valid` out 1: FIFO head valid.
- `msg_ready` in 1: pipe1 consumes head when `msg_valid & msg_ready`.
- `msg_type` out 8: header[21:14].
- `msg_mshrid` out 8: header[13:6].
- `msg_length` out 8: header payload length, header[29:22].
- `msg_addr` out 40: payload flit 1 [39:0].
- `msg_src_chipid` out 14: payload flit 2 [63:50].
- `msg_src_x` out 8: payload flit 2 [49:42].
- `msg_src_y` out 8: payload flit 2 [41:34].
- `msg_data` out 64*MAX_DATA: payload flits 3.., flit 3 in the LSBs.
- `msg_trunc` out 1: the message had more than 2+MAX_DATA payload flits.

## Operation
- Assembler FSM:
  - HDR: accepted flit is the header. Latch type, mshrid and length. Clear the addr, src and data fields and the trunc flag. Set `rem` to length.
    - If length==0, commit immediately and stay in HDR.
    - Otherwise go to PAY with `idx`=1.
  - PAY: each accepted flit is stored by `idx`.
    - `idx`==1: addr.
    - `idx`==2: src fields.
    - 3..2+MAX_DATA: `msg_data[idx-3]`.
    - Higher `idx`: the flit is dropped and trunc is set.
    - Each accepted flit decrements `rem` and increments `idx`, saturating at 255.
    - When `rem` goes 1→0, commit and return to HDR.
- Commit writes the assembled record into the FIFO tail. Fields that were never received are 0.
- `noc1_ready_in` = (count < FIFO_DEPTH). It is combinational from the registered count only. A pop in the same cycle does not raise it.
- Flits are never accepted while ready is low. The assembler holds state across stalls, including mid-message.
- FIFO:
  - Circular, pointers wrap modulo FIFO_DEPTH.
  - Outputs are driven from the head entry.
  - `msg_valid` = (count != 0).
- Ready rule in PAY: ready stays low whenever the FIFO is full, not only on the committing flit. This guarantees a commit never meets a full FIFO.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `rem` and `idx` are 8-bit. Length 255 is legal.
- Reset values:
  - FSM = HDR; count, pointers, `rem`, `idx` = 0.
  - `noc1_ready_in` = 1, `msg_valid` = 0.
  - All message fields and `msg_trunc` = 0.
  - FIFO storage is cleared.
- Reset mid-message discards the partial message and all queued entries.

## Timing
- Latency: last flit of a message accepted at edge N → `msg_valid` high from after edge N, with fields stable.
- Header-only message: visible one cycle after the header is accepted.
- Back-to-back: the header of the next message may be accepted in the cycle right after the last flit of the previous one, with no bubble.
- Throughput: one flit per cycle while not full.
- Head fields stay stable while `msg_valid & ~msg_ready`.
- The next entry appears the cycle after a pop.

## Test plan
- Reset → `noc1_ready_in`=1, `msg_valid`=0, all fields 0. Assert `rst_n` low mid-message → FIFO empty and FSM in HDR on the next cycle.
- Load request: header type 0x0D, length 2, mshrid 0x05, then addr flit 0x00_1234_5670, then src flit chipid 0, x 1, y 2 → `msg_valid` the cycle after flit 3. Required fields: type 0x0D, addr 0x0012345670, src_x 1, src_y 2, data 0, trunc 0.
- Store with length 4 carrying data A and B → `msg_data` = {B,A}, trunc 0. With length 6 → same data, trunc 1; the remaining 2 flits are consumed with ready high.
- Hold `msg_ready`=0 and send 3 length-2 messages → ready drops after the 2nd commit. The 3rd header is accepted only the cycle after the first pop, and all three messages come out in order.
- Length-0 message followed immediately by a length-2 message → two entries, the first with addr 0. Then full-rate flow with `msg_ready`=1 → no bubbles.
- Stall `noc1_valid_in` for 5 cycles between payload flits 1 and 2 → the message is assembled intact, with no early commit.
